// File: rtl/im_tx_fifo.sv
// Transmit-side image FIFO: buffers user words in a circular RAM and emits
// each completed FRAME_LEN-word frame as one AXI4-Stream packet with tlast.
module im_tx_fifo #(
    parameter int FRAME_LEN = 64,
    parameter int DEPTH     = 128,
    parameter int AW        = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arst_for_imfifo,
    input  logic [31:0] wdata_from_user,
    input  logic        wr_en_from_user,
    output logic        ready_to_write,
    output logic [31:0] axi_str_txd_tdata,
    output logic        axi_str_txd_tvalid,
    output logic        axi_str_txd_tlast,
    input  logic        axi_str_txd_tready,
    output logic        overflow,
    output logic [15:0] frames_sent
);

    localparam int FW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] frames_pending_r;
    logic [FW-1:0] wr_frame_cnt_r;
    logic [FW-1:0] beat_cnt_r;
    logic          overflow_r;
    logic [15:0]   frames_sent_r;
    state_t        state_r;

    logic          wr_acc_s;
    logic          wr_drop_s;
    logic          pop_s;
    logic          last_beat_s;
    logic          last_hs_s;
    logic          frame_done_s;
    logic [CW-1:0] count_next_s;
    logic [CW-1:0] fp_next_s;
    logic [FW-1:0] beat_next_s;
    logic [FW-1:0] wr_frame_next_s;
    state_t        state_next_s;

    // Write acceptance, pop handshake and frame-boundary events
    always_comb begin
        wr_acc_s     = wr_en_from_user && (count_r != CW'(DEPTH));
        wr_drop_s    = wr_en_from_user && (count_r == CW'(DEPTH));
        pop_s        = (state_r == SEND) && axi_str_txd_tready;
        last_beat_s  = (beat_cnt_r == FW'(FRAME_LEN - 1));
        last_hs_s    = pop_s && last_beat_s;
        frame_done_s = wr_acc_s && (wr_frame_cnt_r == FW'(FRAME_LEN - 1));
        if (frame_done_s) begin
            wr_frame_next_s = {FW{1'b0}};
        end else if (wr_acc_s) begin
            wr_frame_next_s = wr_frame_cnt_r + FW'(1);
        end else begin
            wr_frame_next_s = wr_frame_cnt_r;
        end
    end

    // Occupancy and pending-frame counters; simultaneous inc/dec cancel
    always_comb begin
        count_next_s = count_r;
        fp_next_s    = frames_pending_r;
        case ({wr_acc_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        case ({frame_done_s, last_hs_s})
            2'b10:   fp_next_s = frames_pending_r + CW'(1);
            2'b01:   fp_next_s = frames_pending_r - CW'(1);
            default: fp_next_s = frames_pending_r;
        endcase
    end

    // TX FSM next-state and beat counter
    always_comb begin
        state_next_s = state_r;
        beat_next_s  = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (frames_pending_r != {CW{1'b0}}) begin
                    state_next_s = SEND;
                    beat_next_s  = {FW{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (last_hs_s) begin
                    beat_next_s  = {FW{1'b0}};
                    state_next_s = (fp_next_s != {CW{1'b0}}) ? SEND : IDLE;
                end else if (pop_s) begin
                    beat_next_s = beat_cnt_r + FW'(1);
                end else begin
                    beat_next_s = beat_cnt_r;
                end
            end
            default: begin
                state_next_s = IDLE;
                beat_next_s  = {FW{1'b0}};
            end
        endcase
    end

    // Control state registers with async reset and synchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r         <= {AW{1'b0}};
            rd_ptr_r         <= {AW{1'b0}};
            count_r          <= {CW{1'b0}};
            frames_pending_r <= {CW{1'b0}};
            wr_frame_cnt_r   <= {FW{1'b0}};
            beat_cnt_r       <= {FW{1'b0}};
            overflow_r       <= 1'b0;
            frames_sent_r    <= 16'd0;
            state_r          <= IDLE;
        end else if (arst_for_imfifo) begin
            wr_ptr_r         <= {AW{1'b0}};
            rd_ptr_r         <= {AW{1'b0}};
            count_r          <= {CW{1'b0}};
            frames_pending_r <= {CW{1'b0}};
            wr_frame_cnt_r   <= {FW{1'b0}};
            beat_cnt_r       <= {FW{1'b0}};
            overflow_r       <= 1'b0;
            frames_sent_r    <= 16'd0;
            state_r          <= IDLE;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (wr_drop_s) begin
                overflow_r <= 1'b1;
            end
            if (last_hs_s) begin
                frames_sent_r <= frames_sent_r + 16'd1;
            end
            count_r          <= count_next_s;
            frames_pending_r <= fp_next_s;
            wr_frame_cnt_r   <= wr_frame_next_s;
            beat_cnt_r       <= beat_next_s;
            state_r          <= state_next_s;
        end
    end

    // Buffer RAM write port; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem[wr_ptr_r] <= wdata_from_user;
        end
    end

    // Outputs decode purely from registered state, so they drop with reset
    always_comb begin
        axi_str_txd_tvalid = (state_r == SEND);
        axi_str_txd_tlast  = (state_r == SEND) && last_beat_s;
        axi_str_txd_tdata  = (state_r == SEND) ? mem[rd_ptr_r] : 32'd0;
        ready_to_write     = (count_r != CW'(DEPTH));
        overflow           = overflow_r;
        frames_sent        = frames_sent_r;
    end

endmodule

// File: tb/tb_im_tx_fifo.sv
// Directed self-checking bench for im_tx_fifo with FRAME_LEN=4, DEPTH=8.
module tb_im_tx_fifo;

    logic        clk;
    logic        rst;
    logic        arst_for_imfifo;
    logic [31:0] wdata_from_user;
    logic        wr_en_from_user;
    logic        ready_to_write;
    logic [31:0] axi_str_txd_tdata;
    logic        axi_str_txd_tvalid;
    logic        axi_str_txd_tlast;
    logic        axi_str_txd_tready;
    logic        overflow;
    logic [15:0] frames_sent;

    int n_checks = 0;
    int n_fails  = 0;

    im_tx_fifo #(.FRAME_LEN(4), .DEPTH(8), .AW(3)) dut (
        .clk                (clk),
        .rst                (rst),
        .arst_for_imfifo    (arst_for_imfifo),
        .wdata_from_user    (wdata_from_user),
        .wr_en_from_user    (wr_en_from_user),
        .ready_to_write     (ready_to_write),
        .axi_str_txd_tdata  (axi_str_txd_tdata),
        .axi_str_txd_tvalid (axi_str_txd_tvalid),
        .axi_str_txd_tlast  (axi_str_txd_tlast),
        .axi_str_txd_tready (axi_str_txd_tready),
        .overflow           (overflow),
        .frames_sent        (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Writes n words base..base+n-1 on consecutive cycles; returns one tick after the last accepting edge
    task automatic write_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wdata_from_user = base + 32'(i);
            wr_en_from_user = 1'b1;
            step();
        end
        wr_en_from_user = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        arst_for_imfifo = 1'b0;
        wdata_from_user = 32'd0;
        wr_en_from_user = 1'b0;
        axi_str_txd_tready = 1'b0;
        #2;
        n_checks++;
        if ({axi_str_txd_tvalid, axi_str_txd_tlast, ready_to_write, overflow} !== 4'b0010) begin
            n_fails++;
            $display("FAIL reset_flags: got v/l/rdy/ovf=%b required 0010",
                     {axi_str_txd_tvalid, axi_str_txd_tlast, ready_to_write, overflow});
        end
        n_checks++;
        if (axi_str_txd_tdata !== 32'd0 || frames_sent !== 16'd0) begin
            n_fails++;
            $display("FAIL reset_values: tdata=%h frames_sent=%0d required 0/0", axi_str_txd_tdata, frames_sent);
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        axi_str_txd_tready = 1'b1;
        write_words(32'h10, 4);
        n_checks++;
        if (axi_str_txd_tvalid !== 1'b0) begin
            n_fails++;
            $display("FAIL single_latency_early: tvalid=%b required 0", axi_str_txd_tvalid);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (axi_str_txd_tvalid !== 1'b1 || axi_str_txd_tdata !== 32'h10 + 32'(k)
                || axi_str_txd_tlast !== (k == 3)) begin
                n_fails++;
                $display("FAIL single_beat%0d: v=%b data=%h last=%b required 1 %h %b",
                         k, axi_str_txd_tvalid, axi_str_txd_tdata, axi_str_txd_tlast, 32'h10 + 32'(k), k == 3);
            end
            step();
        end
        n_checks++;
        if (axi_str_txd_tvalid !== 1'b0 || frames_sent !== 16'd1) begin
            n_fails++;
            $display("FAIL single_end: tvalid=%b frames_sent=%0d required 0/1", axi_str_txd_tvalid, frames_sent);
        end
    endtask

    task automatic test_full_overflow();
        axi_str_txd_tready = 1'b0;
        write_words(32'h20, 8);
        n_checks++;
        if (ready_to_write !== 1'b0 || overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL full_ready: ready=%b overflow=%b required 0/0", ready_to_write, overflow);
        end
        write_words(32'h99, 1);
        n_checks++;
        if (overflow !== 1'b1 || ready_to_write !== 1'b0) begin
            n_fails++;
            $display("FAIL overflow_set: overflow=%b ready=%b required 1/0", overflow, ready_to_write);
        end
        axi_str_txd_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (axi_str_txd_tvalid !== 1'b1 || axi_str_txd_tdata !== 32'h20 + 32'(k)
                || axi_str_txd_tlast !== ((k % 4) == 3)) begin
                n_fails++;
                $display("FAIL b2b_beat%0d: v=%b data=%h last=%b required 1 %h %b",
                         k, axi_str_txd_tvalid, axi_str_txd_tdata, axi_str_txd_tlast, 32'h20 + 32'(k), (k % 4) == 3);
            end
            step();
        end
        n_checks++;
        if (axi_str_txd_tvalid !== 1'b0 || frames_sent !== 16'd3 || ready_to_write !== 1'b1 || overflow !== 1'b1) begin
            n_fails++;
            $display("FAIL b2b_end: v=%b frames_sent=%0d ready=%b ovf=%b required 0/3/1/1",
                     axi_str_txd_tvalid, frames_sent, ready_to_write, overflow);
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] pat;
        int hs;
        int lasts;
        pat = 7'b1101001;
        hs = 0;
        lasts = 0;
        axi_str_txd_tready = 1'b0;
        write_words(32'h40, 4);
        step();
        // pattern applied LSB first: 1,0,0,1,0,1,1
        for (int i = 0; i < 7; i++) begin
            axi_str_txd_tready = pat[i];
            n_checks++;
            if (axi_str_txd_tvalid !== 1'b1 || axi_str_txd_tdata !== 32'h40 + 32'(hs)
                || axi_str_txd_tlast !== (hs == 3)) begin
                n_fails++;
                $display("FAIL stall_cycle%0d: v=%b data=%h last=%b required 1 %h %b",
                         i, axi_str_txd_tvalid, axi_str_txd_tdata, axi_str_txd_tlast, 32'h40 + 32'(hs), hs == 3);
            end
            if (pat[i] && axi_str_txd_tlast === 1'b1) lasts++;
            step();
            if (pat[i]) hs++;
        end
        n_checks++;
        if (lasts !== 1 || axi_str_txd_tvalid !== 1'b0 || frames_sent !== 16'd4) begin
            n_fails++;
            $display("FAIL stall_end: tlast_hs=%0d v=%b frames_sent=%0d required 1/0/4",
                     lasts, axi_str_txd_tvalid, frames_sent);
        end
    endtask

    task automatic test_partial_frame();
        logic seen;
        seen = 1'b0;
        axi_str_txd_tready = 1'b1;
        write_words(32'h50, 3);
        for (int i = 0; i < 12; i++) begin
            if (axi_str_txd_tvalid !== 1'b0) seen = 1'b1;
            step();
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fails++;
            $display("FAIL partial_idle: tvalid seen=%b required 0", seen);
        end
        write_words(32'h53, 1);
        step();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (axi_str_txd_tvalid !== 1'b1 || axi_str_txd_tdata !== 32'h50 + 32'(k)
                || axi_str_txd_tlast !== (k == 3)) begin
                n_fails++;
                $display("FAIL partial_beat%0d: v=%b data=%h last=%b required 1 %h %b",
                         k, axi_str_txd_tvalid, axi_str_txd_tdata, axi_str_txd_tlast, 32'h50 + 32'(k), k == 3);
            end
            step();
        end
        n_checks++;
        if (frames_sent !== 16'd5) begin
            n_fails++;
            $display("FAIL partial_count: frames_sent=%0d required 5", frames_sent);
        end
    endtask

    task automatic test_sync_clear();
        axi_str_txd_tready = 1'b1;
        write_words(32'h60, 4);
        step();
        step();
        step();
        n_checks++;
        if (axi_str_txd_tdata !== 32'h62) begin
            n_fails++;
            $display("FAIL clear_pre: tdata=%h required 62", axi_str_txd_tdata);
        end
        arst_for_imfifo = 1'b1;
        step();
        arst_for_imfifo = 1'b0;
        n_checks++;
        if ({axi_str_txd_tvalid, axi_str_txd_tlast, ready_to_write, overflow} !== 4'b0010
            || axi_str_txd_tdata !== 32'd0) begin
            n_fails++;
            $display("FAIL clear_flags: v/l/rdy/ovf=%b tdata=%h required 0010/0",
                     {axi_str_txd_tvalid, axi_str_txd_tlast, ready_to_write, overflow}, axi_str_txd_tdata);
        end
        n_checks++;
        if (frames_sent !== 16'd0) begin
            n_fails++;
            $display("FAIL clear_frames: frames_sent=%0d required 0", frames_sent);
        end
        write_words(32'h30, 4);
        step();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (axi_str_txd_tvalid !== 1'b1 || axi_str_txd_tdata !== 32'h30 + 32'(k)
                || axi_str_txd_tlast !== (k == 3)) begin
                n_fails++;
                $display("FAIL fresh_beat%0d: v=%b data=%h last=%b required 1 %h %b",
                         k, axi_str_txd_tvalid, axi_str_txd_tdata, axi_str_txd_tlast, 32'h30 + 32'(k), k == 3);
            end
            step();
        end
        n_checks++;
        if (frames_sent !== 16'd1 || axi_str_txd_tvalid !== 1'b0) begin
            n_fails++;
            $display("FAIL fresh_end: frames_sent=%0d v=%b required 1/0", frames_sent, axi_str_txd_tvalid);
        end
    endtask

    task automatic test_async_reset();
        axi_str_txd_tready = 1'b1;
        write_words(32'h70, 4);
        step();
        step();
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (axi_str_txd_tvalid !== 1'b0 || axi_str_txd_tlast !== 1'b0 || axi_str_txd_tdata !== 32'd0) begin
            n_fails++;
            $display("FAIL async_outputs: v=%b l=%b data=%h required 0/0/0",
                     axi_str_txd_tvalid, axi_str_txd_tlast, axi_str_txd_tdata);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        step();
        n_checks++;
        if (frames_sent !== 16'd0 || overflow !== 1'b0 || ready_to_write !== 1'b1 || axi_str_txd_tvalid !== 1'b0) begin
            n_fails++;
            $display("FAIL async_counters: frames_sent=%0d ovf=%b rdy=%b v=%b required 0/0/1/0",
                     frames_sent, overflow, ready_to_write, axi_str_txd_tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_full_overflow();
        test_backpressure();
        test_partial_frame();
        test_sync_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
